// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter.
//   ST_IDLE/ST_START/ST_WAIT : 2-bit state encodings of the arbiter FSM
//   state_e                  : enum built on those encodings
//   clog2_min1()             : index width, never narrower than one bit
package uart_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT
  } state_e;

  // A single requester still needs a one-bit index.
  function automatic int clog2_min1(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_rr_picker.sv
// Round-robin winner selection (purely combinational).
//   req : request vector, one bit per requester
//   ptr : highest-priority index for this decision
//   any : at least one request is set
//   idx : winner, the first set bit scanning ptr, ptr+1, ... wrapping to 0
module uart_rr_picker
  import uart_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  logic [IDW-1:0] idx_lo;
  logic [IDW-1:0] idx_hi;
  logic           hit_hi;

  // Two priority encoders: one over requests at or above ptr, one over all
  // requests. If nothing sits at or above ptr the scan has wrapped, so the
  // lowest request overall wins. Scanning downward leaves the lowest hit.
  always_comb begin
    any    = |req;
    idx_lo = '0;
    idx_hi = '0;
    hit_hi = 1'b0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx_lo = IDW'(i);
        if (i >= int'(ptr)) begin
          idx_hi = IDW'(i);
          hit_hi = 1'b1;
        end
      end
    end
    idx = hit_hi ? idx_hi : idx_lo;
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ requesters.
//   clk, reset_n  : clock (rising edge), asynchronous active-low reset
//   req_valid     : bit i set while requester i holds a byte
//   req_data      : byte i at req_data[i*DBITS +: DBITS]
//   req_ready     : one-cycle pulse, byte of the granted requester accepted
//   req_done      : one-cycle pulse, byte of the granted requester sent
//   tx_start      : one-cycle start pulse to the transmitter
//   tx_din        : latched byte, held for the whole frame
//   tx_done_tick  : transmitter finished the stop bit
//   busy          : high whenever the FSM is not idle
//   gnt_id        : current or most recent grant index
// All outputs come straight from registers.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int DBITS = 8,
  parameter int IDW   = clog2_min1(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*DBITS-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       req_done,
  output logic                  tx_start,
  output logic [DBITS-1:0]      tx_din,
  input  logic                  tx_done_tick,
  output logic                  busy,
  output logic [IDW-1:0]        gnt_id
);

  state_e           state_q,     state_d;
  logic [IDW-1:0]   rr_ptr_q,    rr_ptr_d;
  logic [IDW-1:0]   gnt_id_q,    gnt_id_d;
  logic [DBITS-1:0] tx_din_q,    tx_din_d;
  logic             tx_start_q,  tx_start_d;
  logic [NREQ-1:0]  req_ready_q, req_ready_d;
  logic [NREQ-1:0]  req_done_q,  req_done_d;
  logic             busy_q,      busy_d;

  logic             pick_any;
  logic [IDW-1:0]   pick_idx;

  uart_rr_picker #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_picker (
    .req (req_valid),
    .ptr (rr_ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gnt_id_d    = gnt_id_q;
    tx_din_d    = tx_din_q;
    tx_start_d  = 1'b0;
    req_ready_d = '0;
    req_done_d  = '0;

    unique case (state_q)
      S_IDLE: begin
        // Valid is only looked at here, so a requester still asserting
        // valid after its ready cannot be accepted twice.
        if (pick_any) begin
          tx_din_d    = req_data[int'(pick_idx)*DBITS +: DBITS];
          gnt_id_d    = pick_idx;
          req_ready_d = NREQ'(1) << pick_idx;
          tx_start_d  = 1'b1;
          state_d     = S_START;
        end
      end
      S_START: begin
        // A done tick here belongs to no frame of ours and is ignored.
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (tx_done_tick) begin
          req_done_d = NREQ'(1) << gnt_id_q;
          // Pointer moves past the winner so it ranks last next time.
          rr_ptr_d   = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + IDW'(1);
          state_d    = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      gnt_id_q    <= '0;
      tx_din_q    <= '0;
      tx_start_q  <= 1'b0;
      req_ready_q <= '0;
      req_done_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gnt_id_q    <= gnt_id_d;
      tx_din_q    <= tx_din_d;
      tx_start_q  <= tx_start_d;
      req_ready_q <= req_ready_d;
      req_done_q  <= req_done_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign req_done  = req_done_q;
  assign tx_start  = tx_start_q;
  assign tx_din    = tx_din_q;
  assign busy      = busy_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: the transmitter is stood in for by
// driving tx_done_tick directly a few cycles after each start.
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DBITS = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  reset_n;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*DBITS-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0]       req_done;
  logic                  tx_start;
  logic [DBITS-1:0]      tx_din;
  logic                  tx_done_tick;
  logic                  busy;
  logic [IDW-1:0]        gnt_id;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NREQ  (NREQ),
    .DBITS (DBITS)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .req_done     (req_done),
    .tx_start     (tx_start),
    .tx_din       (tx_din),
    .tx_done_tick (tx_done_tick),
    .busy         (busy),
    .gnt_id       (gnt_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_start"}, 32'(tx_start),  32'd0);
    chk({tag, "_ready"}, 32'(req_ready), 32'd0);
    chk({tag, "_done"},  32'(req_done),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
  endtask

  // One complete grant: requests must already be set up. vw is applied once
  // ready is seen, vd one WAIT cycle later, then the done tick is pulsed.
  task automatic do_frame(input string tag, input int id, input logic [7:0] b,
                          input logic [3:0] vw, input logic [3:0] vd);
    tick();
    chk({tag, "_start"}, 32'(tx_start),  32'd1);
    chk({tag, "_ready"}, 32'(req_ready), 32'(1) << id);
    chk({tag, "_gnt"},   32'(gnt_id),    32'(id));
    chk({tag, "_din"},   32'(tx_din),    32'(b));
    chk({tag, "_busy"},  32'(busy),      32'd1);
    req_valid = vw;
    tick();
    chk({tag, "_wstart"}, 32'(tx_start),  32'd0);
    chk({tag, "_wready"}, 32'(req_ready), 32'd0);
    chk({tag, "_wbusy"},  32'(busy),      32'd1);
    req_valid = vd;
    tick();
    chk({tag, "_wstart2"}, 32'(tx_start), 32'd0);
    chk({tag, "_wdin"},    32'(tx_din),   32'(b));
    chk({tag, "_wdone"},   32'(req_done), 32'd0);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk({tag, "_done"},   32'(req_done), 32'(1) << id);
    chk({tag, "_idle"},   32'(busy),     32'd0);
    chk({tag, "_dstart"}, 32'(tx_start), 32'd0);
  endtask

  logic [9:0] frame;

  initial begin
    reset_n      = 1'b0;
    req_valid    = '0;
    req_data     = {8'h44, 8'h33, 8'h22, 8'hA5};
    tx_done_tick = 1'b0;
    tick();
    tick();
    chk_idle_outputs("rst");
    chk("rst_gnt", 32'(gnt_id), 32'd0);
    chk("rst_din", 32'(tx_din), 32'd0);
    reset_n = 1'b1;
    tick();
    chk_idle_outputs("rel");

    // Test 1: single requester, byte A5, frame bits LSB first.
    req_valid = 4'b0001;
    tick();
    chk("t1_start", 32'(tx_start),  32'd1);
    chk("t1_ready", 32'(req_ready), 32'b0001);
    frame = {1'b1, tx_din, 1'b0};
    chk("t1_frame", 32'(frame), 32'(10'b1101001010));
    req_valid = 4'b0000;
    tick();
    chk("t1_wstart", 32'(tx_start),  32'd0);
    chk("t1_wready", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("t1_wdone", 32'(req_done), 32'd0);
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    chk("t1_done", 32'(req_done), 32'b0001);
    chk("t1_busy", 32'(busy),     32'd0);
    tick();
    chk_idle_outputs("t1_after");

    // Fresh pointer for the ordering test.
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req_data = {8'h44, 8'h33, 8'h22, 8'h11};

    // Test 2: all four held, round-robin 0,1,2,3,0.
    req_valid = 4'b1111;
    do_frame("t2_g0", 0, 8'h11, 4'b1111, 4'b1111);
    do_frame("t2_g1", 1, 8'h22, 4'b1111, 4'b1111);
    do_frame("t2_g2", 2, 8'h33, 4'b1111, 4'b1111);
    do_frame("t2_g3", 3, 8'h44, 4'b1111, 4'b1111);
    do_frame("t2_g4", 0, 8'h11, 4'b1111, 4'b0000);

    // Test 3: pointer wrap, grant 3 then 1001 -> 0 then 3.
    req_valid = 4'b1000;
    do_frame("t3_g3", 3, 8'h44, 4'b1000, 4'b1001);
    do_frame("t3_g0", 0, 8'h11, 4'b1001, 4'b1001);
    do_frame("t3_g3b", 3, 8'h44, 4'b0000, 4'b0000);

    // Test 4: done tick in IDLE ignored; held through START, acts once in WAIT.
    tx_done_tick = 1'b1;
    tick();
    chk_idle_outputs("t4_idle1");
    tick();
    chk_idle_outputs("t4_idle2");
    tx_done_tick = 1'b0;
    req_valid = 4'b0010;
    tick();
    chk("t4_ready", 32'(req_ready), 32'b0010);
    chk("t4_start", 32'(tx_start),  32'd1);
    req_valid    = 4'b0000;
    tx_done_tick = 1'b1;
    tick();
    chk("t4_sdone", 32'(req_done), 32'd0);
    chk("t4_sbusy", 32'(busy),     32'd1);
    tick();
    chk("t4_done", 32'(req_done), 32'b0010);
    chk("t4_busy", 32'(busy),     32'd0);
    tick();
    chk_idle_outputs("t4_after");
    tx_done_tick = 1'b0;

    // Test 5: requester 2 raises then drops during 3's WAIT; pointer is 2.
    req_valid = 4'b1000;
    do_frame("t5_g3", 3, 8'h44, 4'b0100, 4'b0000);
    tick();
    chk_idle_outputs("t5_idle1");
    tick();
    chk_idle_outputs("t5_idle2");
    req_valid = 4'b0001;
    do_frame("t5_g0", 0, 8'h11, 4'b0000, 4'b0000);

    // Test 6: reset in WAIT with pointer at 1; afterwards 1001 must pick 0.
    req_valid = 4'b0010;
    tick();
    chk("t6_ready", 32'(req_ready), 32'b0010);
    req_valid = 4'b0000;
    tick();
    chk("t6_wbusy", 32'(busy), 32'd1);
    reset_n      = 1'b0;
    tx_done_tick = 1'b1;
    #1;
    chk_idle_outputs("t6_async");
    chk("t6_gnt", 32'(gnt_id), 32'd0);
    chk("t6_din", 32'(tx_din), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_idle_outputs("t6_hold");
    end
    tx_done_tick = 1'b0;
    reset_n      = 1'b1;
    tick();
    chk_idle_outputs("t6_rel");
    req_valid = 4'b1001;
    do_frame("t6_g0", 0, 8'h11, 4'b0000, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
